// File: rtl/param_store_buffer.sv
// In-order, byte-masked store buffer with same-cycle load forwarding and a drain handshake.
// Optional build macro STORE_COALESCE_EN merges a store into the youngest entry on a word match.
module param_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [DATA_W-1:0]        st_data,
  input  logic [DATA_W/8-1:0]      st_be,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic [DATA_W/8-1:0]      ld_be,
  output logic                     ld_hit,
  output logic                     ld_partial,
  output logic [DATA_W-1:0]        ld_data,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_data,
  output logic [DATA_W/8-1:0]      mem_be,
  input  logic                     drain_req,
  output logic                     drain_done,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int WA_W  = ADDR_W - OFF_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_DRAINING, S_DONE} state_t;

  state_t             state, state_next;
  logic [PTR_W-1:0]   head, tail, youngest;
  logic [CNT_W-1:0]   count_next;
  logic [WA_W-1:0]    ent_addr [DEPTH];
  logic [DATA_W-1:0]  ent_data [DEPTH];
  logic [BE_W-1:0]    ent_be   [DEPTH];
  logic [WA_W-1:0]    st_word, ld_word;
  logic               push, pop, alloc, merge, merge_hit;
  logic               unused_bits;

  assign st_word     = st_addr[ADDR_W-1:OFF_W];
  assign ld_word     = ld_addr[ADDR_W-1:OFF_W];
  assign unused_bits = ^{st_addr[OFF_W-1:0], ld_addr[OFF_W-1:0]};
  assign youngest    = tail - PTR_W'(1);

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign mem_valid = !empty;
  assign mem_addr  = {ent_addr[head], {OFF_W{1'b0}}};
  assign mem_data  = ent_data[head];
  assign mem_be    = ent_be[head];
  assign pop       = mem_valid && mem_ready;

`ifdef STORE_COALESCE_EN
  // Merging into the head while it retires would lose the new bytes, so allocate instead.
  assign merge_hit = !empty && (ent_addr[youngest] == st_word) && !(pop && (youngest == head));
  assign st_ready  = (state == S_IDLE) && (!full || merge_hit);
`else
  assign merge_hit = 1'b0;
  assign st_ready  = (state == S_IDLE) && !full;
`endif

  assign push       = st_valid && st_ready;
  assign alloc      = push && !merge_hit;
  assign merge      = push && merge_hit;
  assign count_next = count + CNT_W'(alloc) - CNT_W'(pop);
  assign drain_done = (state == S_DONE);

  // NOTE: entry payload is not reset; occupancy (count) alone decides which entries are live.
  always_ff @(posedge clock) begin
    if (alloc) begin
      ent_addr[tail] <= st_word;
      ent_data[tail] <= st_data;
      ent_be[tail]   <= st_be;
    end else if (merge) begin
      for (int b = 0; b < BE_W; b++)
        if (st_be[b]) ent_data[youngest][8*b +: 8] <= st_data[8*b +: 8];
      ent_be[youngest] <= ent_be[youngest] | st_be;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      state <= S_IDLE;
    end else begin
      if (alloc) tail <= tail + PTR_W'(1);
      if (pop)   head <= head + PTR_W'(1);
      count <= count_next;
      state <= state_next;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (drain_req) state_next = S_DRAINING;
      S_DRAINING: if (count_next == '0) state_next = S_DONE;
      S_DONE:     state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  logic [BE_W-1:0]   found;
  logic [DATA_W-1:0] fwd;
  logic [PTR_W-1:0]  idx;

  // Walk oldest to youngest so the youngest matching byte wins each lane.
  always_comb begin
    found = '0;
    fwd   = '0;
    idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (ent_addr[idx] == ld_word)) begin
        for (int b = 0; b < BE_W; b++) begin
          if (ent_be[idx][b]) begin
            found[b]         = 1'b1;
            fwd[8*b +: 8]    = ent_data[idx][8*b +: 8];
          end
        end
      end
    end
    ld_data = '0;
    for (int b = 0; b < BE_W; b++)
      if (found[b] && ld_be[b]) ld_data[8*b +: 8] = fwd[8*b +: 8];
    ld_hit     = (ld_be != '0) && ((found & ld_be) == ld_be);
    ld_partial = (|(found & ld_be)) && !ld_hit;
  end

endmodule
